// File: rtl/sumador_seq_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract sequencer that drives one shared 4-bit
// adder slice one nibble per cycle, LSB first, with a registered carry chain.
module sumador_seq_ctrl #(
  parameter int WIDTH   = 16,
  parameter int NIBBLES = WIDTH / 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iStart,
  input  logic             iSub,
  input  logic [WIDTH-1:0] iOpA,
  input  logic [WIDTH-1:0] iOpB,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oResult,
  output logic             oCarry,
  output logic             oOverflow,
  output logic [3:0]       oAddA,
  output logic [3:0]       oAddB,
  output logic             oAddCin,
  input  logic [3:0]       iAddSum,
  input  logic             iAddCout
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_a, op_b;
  logic             carry;
  logic [IW-1:0]    idx;
  logic             accept;

  assign accept = (state == IDLE || state == DONE) && iStart;

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (iStart) state_nxt = RUN;
      RUN:     if (idx == LAST) state_nxt = DONE;
      DONE:    state_nxt = iStart ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      op_a      <= '0;
      op_b      <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      oResult   <= '0;
      oCarry    <= 1'b0;
      oOverflow <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1: invert B once here, seed the carry with 1.
      op_a      <= iOpA;
      op_b      <= iSub ? ~iOpB : iOpB;
      carry     <= iSub;
      idx       <= '0;
      oResult   <= '0;
      oCarry    <= 1'b0;
      oOverflow <= 1'b0;
    end else if (state == RUN) begin
      oResult[4*idx +: 4] <= iAddSum;
      carry               <= iAddCout;
      idx                 <= idx + 1'b1;
      if (idx == LAST) begin
        oCarry    <= iAddCout;
        oOverflow <= (op_a[WIDTH-1] == op_b[WIDTH-1]) && (iAddSum[3] != op_a[WIDTH-1]);
      end
    end
  end

  // Slice inputs come only from registers so the shared adder sees no
  // combinational path from the request side.
  always_comb begin
    oAddA   = 4'h0;
    oAddB   = 4'h0;
    oAddCin = 1'b0;
    if (state == RUN) begin
      oAddA   = op_a[4*idx +: 4];
      oAddB   = op_b[4*idx +: 4];
      oAddCin = carry;
    end
  end

  assign oBusy = (state == RUN);
  assign oDone = (state == DONE);

endmodule

// File: tb/tb_sumador_seq_ctrl.sv
// Directed bench for sumador_seq_ctrl (WIDTH=16) with a behavioural 4-bit slice.
module tb_sumador_seq_ctrl;

  logic        Clock = 1'b0;
  logic        Reset, iStart, iSub;
  logic [15:0] iOpA, iOpB;
  logic        oBusy, oDone, oCarry, oOverflow, oAddCin, iAddCout;
  logic [15:0] oResult;
  logic [3:0]  oAddA, oAddB, iAddSum;

  int checks = 0;
  int errors = 0;

  sumador_seq_ctrl #(.WIDTH(16)) dut (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iSub(iSub),
    .iOpA(iOpA), .iOpB(iOpB), .oBusy(oBusy), .oDone(oDone),
    .oResult(oResult), .oCarry(oCarry), .oOverflow(oOverflow),
    .oAddA(oAddA), .oAddB(oAddB), .oAddCin(oAddCin),
    .iAddSum(iAddSum), .iAddCout(iAddCout)
  );

  assign {iAddCout, iAddSum} = {1'b0, oAddA} + {1'b0, oAddB} + {4'b0, oAddCin};

  always #5 Clock = ~Clock;

  // Presents one start for a single edge; returns just after that edge.
  task automatic pulse_start(input logic [15:0] a, input logic [15:0] b, input logic sub);
    @(negedge Clock);
    iStart = 1'b1; iOpA = a; iOpB = b; iSub = sub;
    @(posedge Clock); #1;
    iStart = 1'b0; iOpA = '0; iOpB = '0; iSub = 1'b0;
  endtask

  // Waits on negedges for oDone; lat counts cycles after the start edge,
  // busy counts cycles oBusy was seen high; lat = 0 means timeout.
  task automatic wait_done(output int lat, output int busy);
    lat = 0; busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      if (oBusy) busy++;
      if (oDone) begin lat = i + 1; break; end
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1; iStart = 1'b0; iSub = 1'b0; iOpA = '0; iOpB = '0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    checks++;
    if ({oBusy, oDone, oResult, oCarry, oOverflow, oAddA, oAddB, oAddCin} !== 30'b0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b res=%h c=%b v=%b a=%h b=%h cin=%b want all 0",
               oBusy, oDone, oResult, oCarry, oOverflow, oAddA, oAddB, oAddCin);
    end
    Reset = 1'b0;
  endtask

  task automatic test_arith(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic sub, input logic [15:0] er, input logic ec, input logic ev);
    int lat, busy;
    pulse_start(a, b, sub);
    wait_done(lat, busy);
    checks++;
    if (lat !== 5) begin
      errors++; $display("FAIL %s_latency got %0d want 5", name, lat);
    end
    checks++;
    if (busy !== 4) begin
      errors++; $display("FAIL %s_busy_cycles got %0d want 4", name, busy);
    end
    checks++;
    if ({oResult, oCarry, oOverflow} !== {er, ec, ev}) begin
      errors++;
      $display("FAIL %s_result got %h c=%b v=%b want %h c=%b v=%b", name, oResult, oCarry, oOverflow, er, ec, ev);
    end
    @(negedge Clock);
    checks++;
    if (oDone !== 1'b0 || oResult !== er) begin
      errors++; $display("FAIL %s_hold got done=%b res=%h want done=0 res=%h", name, oDone, oResult, er);
    end
  endtask

  task automatic test_slice;
    logic [15:0] ea = 16'h1234;
    logic [15:0] eb = 16'h0FFF;
    logic [3:0]  ec = 4'b1110;
    pulse_start(16'h1234, 16'h0FFF, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      checks++;
      if ({oAddA, oAddB, oAddCin} !== {ea[4*i +: 4], eb[4*i +: 4], ec[i]}) begin
        errors++;
        $display("FAIL slice_cycle%0d got a=%h b=%h cin=%b want a=%h b=%h cin=%b",
                 i, oAddA, oAddB, oAddCin, ea[4*i +: 4], eb[4*i +: 4], ec[i]);
      end
    end
    @(negedge Clock);
    checks++;
    if (oDone !== 1'b1 || {oAddA, oAddB, oAddCin} !== 9'b0) begin
      errors++; $display("FAIL slice_idle got done=%b a=%h b=%h cin=%b want done=1 and 0s", oDone, oAddA, oAddB, oAddCin);
    end
  endtask

  task automatic test_back_to_back;
    int lat, busy;
    pulse_start(16'h0001, 16'h0001, 1'b0);
    @(negedge Clock);
    iStart = 1'b1; iOpA = 16'hAAAA; iOpB = 16'h5555; iSub = 1'b1;
    @(posedge Clock); #1;
    iStart = 1'b0; iOpA = '0; iOpB = '0; iSub = 1'b0;
    wait_done(lat, busy);
    checks++;
    if (lat !== 4 || oResult !== 16'h0002 || oCarry !== 1'b0 || oOverflow !== 1'b0) begin
      errors++; $display("FAIL ignore_start got lat=%0d res=%h c=%b v=%b want lat=4 res=0002 c=0 v=0",
                         lat, oResult, oCarry, oOverflow);
    end
    iStart = 1'b1; iOpA = 16'h00F0; iOpB = 16'h000F; iSub = 1'b0;
    @(posedge Clock); #1;
    iStart = 1'b0; iOpA = '0; iOpB = '0;
    @(negedge Clock);
    checks++;
    if (oBusy !== 1'b1 || oDone !== 1'b0) begin
      errors++; $display("FAIL b2b_no_gap got busy=%b done=%b want busy=1 done=0", oBusy, oDone);
    end
    wait_done(lat, busy);
    checks++;
    if (lat !== 4 || oResult !== 16'h00FF || oCarry !== 1'b0) begin
      errors++; $display("FAIL b2b_result got lat=%0d res=%h c=%b want lat=4 res=00FF c=0", lat, oResult, oCarry);
    end
  endtask

  task automatic test_reset_mid;
    int lat, busy;
    bit seen;
    pulse_start(16'h1111, 16'h2222, 1'b0);
    @(posedge Clock); #1;
    Reset = 1'b1; iStart = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0; iStart = 1'b0;
    @(negedge Clock);
    checks++;
    if ({oBusy, oDone, oResult, oCarry, oOverflow, oAddA, oAddB, oAddCin} !== 30'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs got busy=%b done=%b res=%h c=%b v=%b a=%h b=%h cin=%b want all 0",
               oBusy, oDone, oResult, oCarry, oOverflow, oAddA, oAddB, oAddCin);
    end
    seen = 1'b0;
    repeat (6) begin
      @(negedge Clock);
      if (oDone || oBusy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL reset_mid_abort got activity=1 want 0");
    end
    pulse_start(16'h1111, 16'h2222, 1'b0);
    wait_done(lat, busy);
    checks++;
    if (lat !== 5 || oResult !== 16'h3333 || oCarry !== 1'b0 || oOverflow !== 1'b0) begin
      errors++; $display("FAIL reset_mid_restart got lat=%0d res=%h c=%b v=%b want lat=5 res=3333 c=0 v=0",
                         lat, oResult, oCarry, oOverflow);
    end
  endtask

  initial begin
    test_reset;
    test_arith("add_basic", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
    test_arith("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    test_arith("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    test_arith("sub_neg",   16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    test_arith("sub_ovf",   16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    test_slice;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
